csa_accumulator: RTL and testbench
==================================

Name: csa_accumulator

Overview:
- Sequential consumer of 16-bit carry-save adder output. Accumulates a stream of DATA_W-bit operands in redundant (sum vector S, carry vector C) form, one 3:2 compression per accepted word.
- On the last operand, resolves S + 2*C into a binary sum with a multi-cycle chunked carry-propagate adder.
- Presents the result on a valid/ready output. Sits between the operand source and any block that needs a resolved multi-operand total.

Parameters:
- DATA_W, 16, input operand width.
- ACC_W, 20, accumulator/result width. Results are modulo 2^ACC_W; must be a multiple of CHUNK_W and greater than DATA_W.
- CHUNK_W, 4, bits resolved per cycle in the carry-propagate phase.
- CNT_W, 8, operand counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  DATA_W  operand, zero-extended to ACC_W.
- in_last  input  1  marks the final operand of a group; sampled with in_data.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  resolved sum of the group, mod 2^ACC_W.
- out_count  output  CNT_W  number of operands in the group, saturating at 2^CNT_W-1.
- out_ovf  output  1  sticky: group count exceeded 2^(ACC_W-DATA_W), so the result may have wrapped.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State IDLE; S, C and the resolve carry cleared.
  - in_ready=0 for the reset cycle, then 1.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- Transfers occur only when valid && ready on a rising edge.
- FSM states: IDLE, ACCUM, RESOLVE, HOLD.
  - IDLE: in_ready=1. An accepted operand loads S=in_data, C=0, count=1, ovf=0. Go to RESOLVE if in_last, else ACCUM.
  - ACCUM: in_ready=1. Each accepted operand X (zero-extended) is compressed against T=(C<<1) truncated to ACC_W:
    - S' = S ^ T ^ X.
    - C' = (S&T)|(S&X)|(T&X).
    - count increments, saturating.
    - ovf sets when count would exceed 2^(ACC_W-DATA_W).
    - Go to RESOLVE on in_last. A cycle with no valid input holds all state.
  - RESOLVE: in_ready=0. Lasts exactly ACC_W/CHUNK_W cycles (5 at defaults), counted by chunk index k from 0:
    - Chunk k computes S[k] + T[k] + cy, where T=(C<<1) mod 2^ACC_W.
    - The low CHUNK_W bits are written to result chunk k; the carry-out is registered as cy.
    - cy starts at 0; the final carry-out is discarded.
    - After the last chunk: out_valid=1, state HOLD.
  - HOLD: out_valid=1, and out_sum/out_count/out_ovf stay stable. in_ready=0; no new group is accepted until the result is taken.
    - On out_ready, out_valid drops next cycle and state returns to IDLE.
    - out_sum keeps its last value until the next result is presented.
- Latency: ACC_W/CHUNK_W+1 cycles from acceptance of the last operand to out_valid high.
- Group size 1 (in_last on the first word) is legal: out_sum = in_data, out_count = 1.
- out_ready asserted while out_valid=0 is ignored.
- in_data/in_last are ignored when in_valid=0. in_valid while in_ready=0 is not consumed; the source must hold it.
- Reset mid-group or mid-resolve discards all partial state; no output is produced.
- The ovf limit (16 operands at defaults) is inclusive: 16 operands of 0xFFFF give 0xFFFF0 with ovf=0; the 17th sets ovf.

Decomposition:
- Shared package holds:
  - DATA_W / ACC_W / CHUNK_W / CNT_W defaults.
  - The FSM state enum {IDLE, ACCUM, RESOLVE, HOLD}.
  - The constant NUM_CHUNKS = ACC_W/CHUNK_W.
- One natural sub-module, csa_compress_row: parameterised-width combinational 3:2 row, instanced once for the ACCUM update.
- The chunk adder stays inline.

Test Plan:
- Single operand: 0x1234 with in_last -> out_sum=0x01234, count=1, ovf=0; out_valid rises 6 cycles after acceptance.
- Three operands: 0x0001, 0x0002, 0x0003 back-to-back, last on third -> out_sum=0x00006, count=3.
- Full carry chain: 16 × 0xFFFF -> out_sum=0xFFFF0, count=16, ovf=0. A 17th 0xFFFF gives 0x0FFEF with ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. Then one out_ready pulse -> out_valid drops and in_ready=1 on the next cycle.
- Input gaps: deassert in_valid between operands 0x8000 and 0x8000 (last) -> out_sum=0x10000, count=2.
- Reset mid-RESOLVE: assert rst_n=0 during chunk 2 -> out_valid=0 immediately. Next group 0x0005 (last) -> out_sum=0x00005.

Source files
------------

// File: rtl/csa_accumulator_pkg.sv
// rtl/csa_accumulator_pkg.sv - shared widths, chunk count and FSM state type for csa_accumulator
package csa_accumulator_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ACC_W   = 20;
    localparam int DEF_CHUNK_W = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int NUM_CHUNKS  = DEF_ACC_W / DEF_CHUNK_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/csa_compress_row.sv
// rtl/csa_compress_row.sv - combinational W-bit 3:2 carry-save compression row
// Ports: a, b, c in; sum = a^b^c, carry = majority(a,b,c), unshifted (weight 2 is applied by the user).
module csa_compress_row #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save operand accumulator with chunked carry-propagate resolve
// Ports: clk/rst_n; operand stream in_valid/in_ready/in_data/in_last;
//        result out_valid/out_ready/out_sum/out_count/out_ovf.
module csa_accumulator
    import csa_accumulator_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CHUNK_W = DEF_CHUNK_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int NCH     = ACC_W / CHUNK_W;
    localparam int K_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OVF_LIM = 1 << (ACC_W - DATA_W);

    state_t             state_q, state_d;
    logic               init_q, init_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic               cy_q, cy_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               oovf_q, oovf_d;

    logic [ACC_W-1:0]   x_ext;
    logic [ACC_W-1:0]   t_vec;
    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   row_carry;
    logic [CHUNK_W:0]   chunk;
    logic               in_fire;
    int                 base;

    assign x_ext = ACC_W'(in_data);
    // Carry vector carries weight 2; the bit shifted out the top is dropped (mod 2^ACC_W).
    assign t_vec = c_q << 1;

    // init_q keeps in_ready low for the first cycle out of reset.
    assign in_ready  = init_q && ((state_q == IDLE) || (state_q == ACCUM));
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_sum   = sum_q;
    assign out_count = ocnt_q;
    assign out_ovf   = oovf_q;

    csa_compress_row #(.W(ACC_W)) u_row (
        .a     (s_q),
        .b     (t_vec),
        .c     (x_ext),
        .sum   (row_sum),
        .carry (row_carry)
    );

    always_comb begin
        state_d = state_q;
        init_d  = 1'b1;
        s_d     = s_q;
        c_d     = c_q;
        cy_d    = cy_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        base    = int'(k_q) * CHUNK_W;
        chunk   = {1'b0, s_q[base +: CHUNK_W]} + {1'b0, t_vec[base +: CHUNK_W]}
                + (CHUNK_W + 1)'(cy_q);

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    s_d     = x_ext;
                    c_d     = '0;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    cy_d    = 1'b0;
                    k_d     = '0;
                    state_d = in_last ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    s_d = row_sum;
                    c_d = row_carry;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    // Count is about to pass the limit where the sum can no longer fit.
                    if (int'(cnt_q) >= OVF_LIM) ovf_d = 1'b1;
                    if (in_last) begin
                        cy_d    = 1'b0;
                        k_d     = '0;
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                // Resolved chunk overwrites S in place; S[k] is not needed again.
                s_d[base +: CHUNK_W] = chunk[CHUNK_W-1:0];
                cy_d = chunk[CHUNK_W];
                if (k_q == K_W'(NCH - 1)) begin
                    sum_d   = s_d;
                    ocnt_d  = cnt_q;
                    oovf_d  = ovf_q;
                    state_d = HOLD;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            s_q     <= '0;
            c_q     <= '0;
            cy_q    <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator against an arithmetic sum model
module tb_csa_accumulator;
    import csa_accumulator_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ACC_W;
    localparam int CW = DEF_CHUNK_W;
    localparam int NW = DEF_CNT_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_sum;
    logic [NW-1:0] out_count;
    logic          out_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    longint unsigned m_sum = 0;
    int m_cnt = 0;

    csa_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_sum();
        return 32'(AW'(m_sum));
    endfunction

    function automatic logic [31:0] exp_cnt();
        return (m_cnt > (1 << NW) - 1) ? 32'((1 << NW) - 1) : 32'(m_cnt);
    endfunction

    function automatic logic [31:0] exp_ovf();
        return (m_cnt > (1 << (AW - DW))) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Enters and leaves on a falling edge; returns just after the accepting rising edge.
    task automatic send(input logic [DW-1:0] d, input logic last, input bit rnd_ready);
        int guard = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        out_ready = (rnd_ready && !last) ? 1'($urandom) : 1'b0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("send_accept", 32'(guard < 100), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = DW'($urandom);
        in_last   = 1'($urandom);
        out_ready = 1'b0;
        m_sum += 64'(d);
        m_cnt++;
    endtask

    task automatic wait_result(input string tag);
        int lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(AW / CW + 1));
        check({tag, "_sum"}, 32'(out_sum), exp_sum());
        check({tag, "_count"}, 32'(out_count), exp_cnt());
        check({tag, "_ovf"}, 32'(out_ovf), exp_ovf());
        check({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        m_sum = 0;
        m_cnt = 0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        check("rst_release_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single operand group
        send(16'h1234, 1'b1, 1'b0);
        wait_result("single");
        take("single");

        // Three operands back to back
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        send(16'h0003, 1'b1, 1'b0);
        wait_result("three");
        take("three");

        // Full carry chain, at and one past the overflow limit
        for (int i = 0; i < 16; i++) send(16'hFFFF, 1'(i == 15), 1'b0);
        check("chain16_model", exp_sum(), 32'h000FFFF0);
        wait_result("chain16");
        take("chain16");
        for (int i = 0; i < 17; i++) send(16'hFFFF, 1'(i == 16), 1'b0);
        check("chain17_model", exp_sum(), 32'h0000FFEF);
        wait_result("chain17");
        take("chain17");

        // Backpressure with a new operand waiting on the input
        send(16'h00AA, 1'b0, 1'b0);
        send(16'h0055, 1'b1, 1'b0);
        wait_result("bp");
        in_valid = 1'b1;
        in_data  = 16'h0007;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(out_sum), 32'h000FF);
            check("bp_count", 32'(out_count), 32'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        take("bp");
        m_sum = 7;
        m_cnt = 1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("held_word");
        take("held_word");

        // Input gaps between operands
        send(16'h8000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send(16'h8000, 1'b1, 1'b0);
        wait_result("gaps");
        take("gaps");

        // Reset during the resolve phase
        send(16'h1111, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_sum = 0;
        m_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end
        send(16'h0005, 1'b1, 1'b0);
        wait_result("after_rst");
        take("after_rst");

        // Randomized groups with gaps and delayed result acceptance
        for (int g = 0; g < 12; g++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                send(DW'($urandom), 1'(i == n - 1), 1'b1);
                if (i != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_result("rand");
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rand_hold_sum", 32'(out_sum), exp_sum());
            end
            take("rand");
        end

        // Count saturation
        for (int i = 0; i < 300; i++) send(DW'($urandom), 1'(i == 299), 1'b0);
        wait_result("sat");
        take("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
